// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: round shift table, PC1/PC2 bit tables,
// FSM state encoding and the 28-bit half-key rotate helper.
package des_pkg;

  localparam int NUM_ROUNDS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Left-rotate amount applied to C and D to produce round n+1 (index n)
  localparam logic [1:0] DES_SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Entry i names the DES input bit (1-based, MSB first) feeding output bit i+1
  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // dir=0 rotates left, dir=1 rotates right; amt is 0..2
  function automatic logic [27:0] rot28(input logic [27:0] x,
                                        input logic [1:0]  amt,
                                        input logic        dir);
    logic [27:0] r;
    r = x;
    case ({dir, amt})
      3'b001:  r = {x[26:0], x[27]};
      3'b010:  r = {x[25:0], x[27:26]};
      3'b101:  r = {x[0], x[27:1]};
      3'b110:  r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc1.sv
// DES Permuted Choice 1: 64-bit key (bit 63 = DES bit 1) to 56-bit C0D0.
// Parity bits 8,16,..,64 are simply never selected.
module des_pc1
  import des_pkg::*;
(
  input  logic [63:0] key,
  output logic [55:0] pc1
);

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1[55-i] = key[64-PC1_TAB[i]];
  end

endmodule

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: 56-bit {C,D} (DES bit n = bit 56-n) to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[47-i] = cd[56-PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: accepts a key, then streams the 16 round subkeys over a
// valid/ready port in K1..K16 (encrypt) or K16..K1 (decrypt) order.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] des_key_in,
  input  logic        decrypt,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_round,
  output logic        done
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is never withdrawn and data holds until it transfers.

  state_t      state, state_next;
  logic [27:0] c_reg, d_reg, c_next, d_next;
  logic [3:0]  cnt, cnt_next;
  logic        dir, dir_next;
  logic        done_next;
  logic [55:0] pc1_key;
  logic [55:0] pc1_rot;
  logic [1:0]  shift_amt;
  logic        key_hs, sub_hs;

  des_pc1 u_pc1 (
    .key (des_key_in),
    .pc1 (pc1_key)
  );

  des_pc2 u_pc2 (
    .cd     ({c_reg, d_reg}),
    .subkey (subkey)
  );

  assign key_ready    = (state == IDLE);
  assign subkey_valid = (state == RUN);
  assign subkey_round = dir ? (4'd15 - cnt) : cnt;
  assign key_hs       = key_valid & key_ready;
  assign sub_hs       = subkey_valid & subkey_ready;

  // Decrypt walks backwards: undo the shift that produced the current round
  assign shift_amt = dir ? DES_SHIFT[4'd15 - cnt] : DES_SHIFT[cnt + 4'd1];

  assign pc1_rot = {rot28(pc1_key[55:28], 2'd1, 1'b0),
                    rot28(pc1_key[27:0],  2'd1, 1'b0)};

  always_comb begin
    state_next = state;
    c_next     = c_reg;
    d_next     = d_reg;
    cnt_next   = cnt;
    dir_next   = dir;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (key_hs) begin
          dir_next   = decrypt;
          cnt_next   = 4'd0;
          state_next = RUN;
          // C16D16 equals C0D0, so decrypt starts from the unrotated PC1 value
          if (decrypt) begin
            c_next = pc1_key[55:28];
            d_next = pc1_key[27:0];
          end else begin
            c_next = pc1_rot[55:28];
            d_next = pc1_rot[27:0];
          end
        end
      end
      RUN: begin
        if (sub_hs) begin
          if (cnt == 4'(NUM_ROUNDS - 1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt + 4'd1;
            c_next   = rot28(c_reg, shift_amt, dir);
            d_next   = rot28(d_reg, shift_amt, dir);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c_reg <= '0;
      d_reg <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      c_reg <= c_next;
      d_reg <= d_next;
      cnt   <= cnt_next;
      dir   <= dir_next;
      done  <= done_next;
    end
  end

endmodule
